// File: rtl/genius_pkg.sv
// Shared state encoding, symbol/memory sizing, LED decode and LFSR taps for the Genius sequencer.
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHOW  = 3'd1,
        ST_GAP   = 3'd2,
        ST_INPUT = 3'd3,
        ST_NEXT  = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOSE  = 3'd6
    } state_e;

    localparam int SYM_W     = 2;
    localparam int MEM_DEPTH = 16;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] onehot(input logic [SYM_W-1:0] sym);
        return 4'b0001 << sym;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 8-bit Fibonacci LFSR supplying random colour symbols.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       R,
    output logic [7:0] q
);

    // Shift every cycle; the feedback bit enters at the LSB.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/genius_sequencer.sv
// Genius (Simon) game controller: grows, plays back and checks a colour sequence.
// Optional per-press timeout is enabled with the GENIUS_TIMEOUT_EN macro.
module genius_sequencer
    import genius_pkg::*;
#(
    parameter int         MAX_ROUND      = 15,
    parameter int         HOLD_CYCLES    = 4,
    parameter logic [7:0] SEED           = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       R,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [3:0] round,
    output logic       busy,
    output logic       input_phase,
    output logic       win,
    output logic       lose
);

    localparam int                HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam int                TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        ROUND_LAST = 4'(MAX_ROUND);

    state_e            state_q, state_d;
    logic [3:0]        pos_q, pos_d;
    logic [3:0]        round_q, round_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SYM_W-1:0]  mem_q [MEM_DEPTH];
    logic              mem_we;
    logic [3:0]        mem_waddr;
    logic [SYM_W-1:0]  mem_wdata;
    logic [SYM_W-1:0]  show_sym;
    logic [3:0]        led_q, led_d;
    logic              busy_q, busy_d, inp_q, inp_d, win_q, win_d, lose_q, lose_d;
    logic [7:0]        lfsr_s;
    logic              unused_s;
`ifdef GENIUS_TIMEOUT_EN
    logic [TO_W-1:0]   to_q, to_d;
`endif

    genius_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .R   (R),
        .q   (lfsr_s)
    );

    assign unused_s = ^{lfsr_s[7:SYM_W], TO_LAST};

    // Next-state logic plus registered-output decode of the upcoming state.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        round_d   = round_q;
        hold_d    = hold_q;
        mem_we    = 1'b0;
        mem_waddr = 4'd0;
        mem_wdata = lfsr_s[SYM_W-1:0];
`ifdef GENIUS_TIMEOUT_EN
        to_d      = (state_q == ST_INPUT) ? to_q : {TO_W{1'b0}};
`endif
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    mem_we    = 1'b1;
                    mem_waddr = 4'd0;
                    round_d   = 4'd0;
                    pos_d     = 4'd0;
                    hold_d    = {HOLD_W{1'b0}};
                    state_d   = ST_SHOW;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = {HOLD_W{1'b0}};
                    state_d = ST_GAP;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = {HOLD_W{1'b0}};
                    if (pos_q == round_q) begin
                        pos_d   = 4'd0;
                        state_d = ST_INPUT;
                    end else begin
                        pos_d   = pos_q + 4'd1;
                        state_d = ST_SHOW;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_INPUT: begin
                if (btn == 4'b0000) begin
`ifdef GENIUS_TIMEOUT_EN
                    if (to_q == TO_LAST) begin
                        state_d = ST_LOSE;
                    end else begin
                        to_d    = to_q + TO_W'(1);
                    end
`else
                    state_d = ST_INPUT;
`endif
                end else if (btn == onehot(mem_q[pos_q])) begin
`ifdef GENIUS_TIMEOUT_EN
                    to_d = {TO_W{1'b0}};
`endif
                    if (pos_q == round_q) begin
                        state_d = ST_NEXT;
                    end else begin
                        pos_d   = pos_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LOSE;
                end
            end
            ST_NEXT: begin
                if (round_q == ROUND_LAST) begin
                    state_d   = ST_WIN;
                end else begin
                    round_d   = round_q + 4'd1;
                    mem_we    = 1'b1;
                    mem_waddr = round_q + 4'd1;
                    pos_d     = 4'd0;
                    hold_d    = {HOLD_W{1'b0}};
                    state_d   = ST_SHOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Forward a symbol written this cycle so the first lit LED is correct.
        if (mem_we && (mem_waddr == pos_d)) begin
            show_sym = mem_wdata;
        end else begin
            show_sym = mem_q[pos_d];
        end

        case (state_d)
            ST_SHOW: led_d = onehot(show_sym);
            ST_WIN:  led_d = 4'b1111;
            default: led_d = 4'b0000;
        endcase
        busy_d = (state_d == ST_SHOW) || (state_d == ST_GAP) ||
                 (state_d == ST_INPUT) || (state_d == ST_NEXT);
        inp_d  = (state_d == ST_INPUT);
        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
    end

    // State, counters, sequence memory and output registers.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= ST_IDLE;
            pos_q   <= 4'd0;
            round_q <= 4'd0;
            hold_q  <= {HOLD_W{1'b0}};
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= {SYM_W{1'b0}};
            end
            led_q   <= 4'b0000;
            busy_q  <= 1'b0;
            inp_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            round_q <= round_d;
            hold_q  <= hold_d;
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
            led_q   <= led_d;
            busy_q  <= busy_d;
            inp_q   <= inp_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

`ifdef GENIUS_TIMEOUT_EN
    // Per-press idle counter.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            to_q <= {TO_W{1'b0}};
        end else begin
            to_q <= to_d;
        end
    end
`endif

    assign led         = led_q;
    assign round       = round_q;
    assign busy        = busy_q;
    assign input_phase = inp_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_genius_sequencer.sv
// Scoreboard bench for genius_sequencer: a reference LFSR/sequence model predicts
// every displayed symbol, win and loss; a monitor compares them as the DUT shows them.
module tb_genius_sequencer;

    localparam int MAXR = 3;
    localparam int HOLD = 4;
    localparam logic [1:0] K_SHOW = 2'd0, K_WIN = 2'd1, K_LOSE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] led;
        logic [3:0] rnd;
    } ev_t;

    logic       clk = 1'b0;
    logic       R, start, noise;
    logic [3:0] btn;
    logic [3:0] led, round;
    logic       busy, input_phase, win, lose;

    int errors = 0;
    int checks = 0;
    ev_t exp_q[$];
    logic [7:0] m_lfsr = 8'hA5;
    logic [1:0] seq [0:15];
    logic [3:0] led_prev = 4'd0;
    logic       win_prev = 1'b0, lose_prev = 1'b0;

    genius_sequencer #(
        .MAX_ROUND(MAXR), .HOLD_CYCLES(HOLD), .SEED(8'hA5), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .R(R), .start(start), .btn(btn), .led(led), .round(round),
        .busy(busy), .input_phase(input_phase), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Reference LFSR, stepped in lockstep with the design's free-running one.
    always @(posedge clk or posedge R) begin
        if (R) m_lfsr <= 8'hA5;
        else   m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [3:0] l, input logic [3:0] r);
        ev_t e;
        e.kind = kind; e.led = l; e.rnd = r;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input logic [1:0] kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected event kind=%0d led=%b round=%0d at %0t",
                     kind, led, round, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.led !== led || e.rnd !== round) begin
                errors++;
                $display("FAIL scoreboard: got kind=%0d led=%b round=%0d expected kind=%0d led=%b round=%0d at %0t",
                         kind, led, round, e.kind, e.led, e.rnd, $time);
            end
        end
    endtask

    // Monitor: every newly lit symbol, win rise and lose rise is a scoreboard event.
    always @(negedge clk) begin
        if (!R) begin
            if (led != 4'd0 && !win && (led_prev == 4'd0 || win_prev)) mon_check(K_SHOW);
            if (win && !win_prev)   mon_check(K_WIN);
            if (lose && !lose_prev) mon_check(K_LOSE);
        end
        led_prev  <= led;
        win_prev  <= win;
        lose_prev <= lose;
    end

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        seq[0] = m_lfsr[1:0];
        push_ev(K_SHOW, oh(seq[0]), 4'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_input();
        int n = 0;
        while (!input_phase && n < 2000) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                if (led != 4'd0 && $urandom_range(0, 1) == 1) start = 1'b1;
                else btn = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            start = 1'b0;
            btn = 4'd0;
            n++;
        end
        chk("wait_input", {31'd0, input_phase}, 32'd1);
    endtask

    // Replays round r correctly, then predicts what the one-cycle NEXT state leads to.
    task automatic press_round(input int r, input int first_idle);
        int idle;
        for (int i = 0; i <= r; i++) begin
            idle = (i == 0 && first_idle >= 0) ? first_idle : int'($urandom_range(0, 2));
            repeat (idle) @(negedge clk);
            btn = oh(seq[i]);
            @(negedge clk);
            btn = 4'd0;
        end
        if (r == MAXR) begin
            push_ev(K_WIN, 4'b1111, 4'(r));
        end else begin
            seq[r+1] = m_lfsr[1:0];
            for (int j = 0; j <= r + 1; j++) push_ev(K_SHOW, oh(seq[j]), 4'(r + 1));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_led"}, {28'd0, led}, 32'd0);
        chk({tag, "_round"}, {28'd0, round}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_input"}, {31'd0, input_phase}, 32'd0);
        chk({tag, "_win"}, {31'd0, win}, 32'd0);
        chk({tag, "_lose"}, {31'd0, lose}, 32'd0);
    endtask

    initial begin
        int n;
        start = 1'b0; btn = 4'd0; R = 1'b0; noise = 1'b0;
        #1 R = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        R = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Game 1: playback timing on round 0, then a full correct game with noise.
        start_game();
        for (int k = 0; k < 2 * HOLD; k++) begin
            chk("play_led", {28'd0, led}, {28'd0, (k < HOLD) ? oh(seq[0]) : 4'd0});
            chk("play_input_low", {31'd0, input_phase}, 32'd0);
            @(negedge clk);
        end
        chk("play_input_high", {31'd0, input_phase}, 32'd1);
        press_round(0, -1);
        noise = 1'b1;
        for (int r = 1; r <= MAXR; r++) begin
            wait_input();
            press_round(r, -1);
        end
        noise = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("win_flag", {31'd0, win}, 32'd1);
            chk("win_led", {28'd0, led}, 32'hF);
            chk("win_round", {28'd0, round}, MAXR);
            chk("win_busy", {31'd0, busy}, 32'd0);
        end

        // Game 2 (restart from WIN): wrong single button on step 0 of round 1.
        start_game();
        chk("restart_win_clear", {31'd0, win}, 32'd0);
        wait_input();
        press_round(0, -1);
        wait_input();
        btn = oh(seq[0] + 2'd1);
        push_ev(K_LOSE, 4'd0, 4'd1);
        @(negedge clk);
        btn = 4'd0;
        chk("wrong_lose", {31'd0, lose}, 32'd1);
        chk("wrong_round", {28'd0, round}, 32'd1);

        // Game 3 (restart from LOSE): multi-bit press loses.
        start_game();
        chk("restart_lose_clear", {31'd0, lose}, 32'd0);
        chk("restart_round0", {28'd0, round}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_input();
        btn = 4'b0011;
        push_ev(K_LOSE, 4'd0, 4'd0);
        @(negedge clk);
        btn = 4'd0;
        chk("multibit_lose", {31'd0, lose}, 32'd1);

        // Game 4: press-timeout boundary, then advance to round 2.
        start_game();
        wait_input();
`ifdef GENIUS_TIMEOUT_EN
        push_ev(K_LOSE, 4'd0, 4'd0);
        repeat (63) @(negedge clk);
        chk("timeout_not_yet", {31'd0, lose}, 32'd0);
        @(negedge clk);
        chk("timeout_lose", {31'd0, lose}, 32'd1);
        start_game();
        wait_input();
        press_round(0, 63);
        wait_input();
        chk("late_press_ok", {31'd0, lose}, 32'd0);
        chk("late_press_round", {28'd0, round}, 32'd1);
`else
        repeat (100) @(negedge clk);
        chk("no_timeout_lose", {31'd0, lose}, 32'd0);
        chk("no_timeout_wait", {31'd0, input_phase}, 32'd1);
        press_round(0, -1);
        wait_input();
`endif
        press_round(1, -1);

        // Reset in SHOW of round 2 discards the game; the LFSR restarts from SEED.
        n = 0;
        while (led == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("show_round2_seen", {31'd0, (led != 4'd0)}, 32'd1);
        chk("show_round2", {28'd0, round}, 32'd2);
        #2 R = 1'b1;
        #1 chk_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        chk_all_zero("reset_hold");
        R = 1'b0;
        start_game();
        wait_input();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
